serial_adder_ctrl: RTL

//  Bit-serial adder controller: sequences a one-bit full-adder slice over two

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_fa_bit.sv | 30 +++
 rtl/serial_adder_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder controller.
//   - state_t  : controller state encoding (IDLE / RUN / DONE)
//   - STATE_W  : width of the state encoding
//   - cnt_width: bit-counter width for a given operand width (minimum 1)
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A 1-bit operand still needs a 1-bit counter; $clog2(1) would give 0.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// serial_fa_bit
//   Combinational one-bit full adder built from two half adders and an OR.
//   Ports:
//     a, b  in  operand bits
//     cin   in  carry in
//     s     out sum bit
//     cout  out carry out
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic hs1_s;
  logic hs1_c;
  logic hs2_c;

  // first half adder: a + b
  assign hs1_s = a ^ b;
  assign hs1_c = a & b;

  // second half adder: partial sum + cin
  assign s     = hs1_s ^ cin;
  assign hs2_c = hs1_s & cin;

  assign cout  = hs1_c | hs2_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller. Captures two WIDTH-bit operands on an
//   accepted start, feeds them LSB first through a one-bit full adder, one
//   bit per clock, and presents sum/carry_out with a one-cycle done strobe.
//
//   Optional feature: define SERIAL_ADD_SUB_EN to add the 'sub' port. With
//   sub=1 the b bits are inverted into the adder and the carry starts at 1,
//   giving op_a - op_b; carry_out=1 then means no borrow.
//
//   Parameters:
//     WIDTH      operand/result width (>=1)
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      request, sampled only while ready=1
//     op_a/op_b  operands, captured on the accepted start edge
//     sub        subtract select (SERIAL_ADD_SUB_EN only)
//     ready      high in IDLE
//     busy       high in RUN
//     done       one-cycle strobe in DONE
//     sum        result, held until the next completed operation
//     carry_out  final carry, held with sum
//
//   Handshake: a request is accepted on any rising edge where start=1 and
//   ready=1. start is ignored in every other state; there is no back-pressure
//   on done, which is a single-cycle strobe that the requester must observe.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             c_reg;
  logic [CNT_W-1:0] bit_cnt;

  logic             accept;
  logic             last_bit;
  logic             b_bit;
  logic             carry_init;
  logic             s_bit;
  logic             c_next;

`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q;
  // Inverting b at the slice input is equivalent to inverting it on capture.
  assign b_bit      = b_sr[0] ^ sub_q;
  assign carry_init = sub;
`else
  assign b_bit      = b_sr[0];
  assign carry_init = 1'b0;
`endif

  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  serial_fa_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_bit),
    .cin  (c_reg),
    .s    (s_bit),
    .cout (c_next)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = s_bit;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)    state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_IDLE);
    busy  = (state == ST_RUN);
    done  = (state == ST_DONE);
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      c_reg     <= 1'b0;
      bit_cnt   <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else if (accept) begin
      a_sr    <= op_a;
      b_sr    <= op_b;
      res_sr  <= '0;
      c_reg   <= carry_init;
      bit_cnt <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub;
`endif
    end else if (state == ST_RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= res_next;
      c_reg   <= c_next;
      bit_cnt <= bit_cnt + 1'b1;
      // Result becomes visible only once the whole word is formed.
      if (last_bit) begin
        sum       <= res_next;
        carry_out <= c_next;
      end
    end
  end

endmodule
